medida_serial_tx: RTL and testbench

- Downstream consumer of interface_hcsr04. It captures the 3-digit BCD distance `medida[11:0]` when `pronto_medida` pulses.
- It sends the value over an asynchronous serial line (UART 8N1) as four ASCII characters: hundreds, tens, units, then '#'. Example: 100 cm is sent as "100#".
- It feeds the lab's serial terminal / PC logger in the sonar top level.

---
 rtl/medida_serial_tx.sv | 166 ++++++++++++++++
 tb/tb_medida_serial_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/medida_serial_tx.sv
// Sends a latched 3-digit BCD distance over UART 8N1 as four ASCII characters
// (hundreds, tens, units, '#'), with busy and done indications for the host FSM.
module medida_serial_tx #(
    parameter int BIT_TICKS = 434,
    parameter int CNT_W     = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] medida,
    input  logic        pronto_medida,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    if (BIT_TICKS < 2 || (64'd1 << CNT_W) <= 64'(BIT_TICKS)) begin : g_param_check
        $error("medida_serial_tx: BIT_TICKS must be >= 2 and fit in CNT_W bits");
    end

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_DADOS = 4'd2,
        S_STOP  = 4'd3,
        S_FIM   = 4'd4
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] tick_q,     tick_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [1:0]       char_idx_q, char_idx_d;
    logic [11:0]      medida_q,   medida_d;
    logic             serial_q,   serial_d;
    logic             ocupado_q,  ocupado_d;
    logic             pronto_q,   pronto_d;

    logic             tick_wrap;
    logic [2:0]       bit_idx_inc;
    logic [7:0]       cur_char;

    // Non-BCD nibbles are shown as '?' so a corrupted measurement is visible on the terminal.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        logic [7:0] c;
        if (d > 4'd9) begin
            c = 8'h3F;
        end else begin
            c = 8'h30 + {4'h0, d};
        end
        return c;
    endfunction

    assign tick_wrap   = (tick_q == TICK_LAST);
    assign bit_idx_inc = bit_idx_q + 3'd1;

    always_comb begin
        cur_char = 8'h23;
        case (char_idx_q)
            2'd0:    cur_char = digit_ascii(medida_q[11:8]);
            2'd1:    cur_char = digit_ascii(medida_q[7:4]);
            2'd2:    cur_char = digit_ascii(medida_q[3:0]);
            default: cur_char = 8'h23;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_wrap ? '0 : tick_q + TICK_ONE;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        medida_d   = medida_q;
        serial_d   = serial_q;
        ocupado_d  = ocupado_q;
        pronto_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d    = '0;
                serial_d  = 1'b1;
                ocupado_d = 1'b0;
                if (pronto_medida) begin
                    medida_d   = medida;
                    char_idx_d = 2'd0;
                    state_d    = S_START;
                    serial_d   = 1'b0;
                    ocupado_d  = 1'b1;
                end
            end
            S_START: begin
                if (tick_wrap) begin
                    state_d   = S_DADOS;
                    bit_idx_d = 3'd0;
                    serial_d  = cur_char[0];
                end
            end
            S_DADOS: begin
                if (tick_wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_inc;
                        serial_d  = cur_char[bit_idx_inc];
                    end
                end
            end
            S_STOP: begin
                if (tick_wrap) begin
                    if (char_idx_q < 2'd3) begin
                        // Next character follows immediately, no idle gap on the line.
                        char_idx_d = char_idx_q + 2'd1;
                        state_d    = S_START;
                        serial_d   = 1'b0;
                    end else begin
                        state_d  = S_FIM;
                        serial_d = 1'b1;
                        pronto_d = 1'b1;
                    end
                end
            end
            S_FIM: begin
                tick_d    = '0;
                state_d   = S_IDLE;
                serial_d  = 1'b1;
                ocupado_d = 1'b0;
            end
            default: begin
                tick_d    = '0;
                state_d   = S_IDLE;
                serial_d  = 1'b1;
                ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= 3'd0;
            char_idx_q <= 2'd0;
            medida_q   <= 12'h000;
            serial_q   <= 1'b1;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            medida_q   <= medida_d;
            serial_q   <= serial_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign saida_serial = serial_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;
    assign db_estado    = state_q;

endmodule

// File: tb/tb_medida_serial_tx.sv
// Scoreboard bench: stimulus pushes expected messages, a UART-receiver monitor per
// instance (A: 434 ticks/bit, B: 4 ticks/bit) decodes the line and compares.
module tb_medida_serial_tx;

    localparam int BT_A = 434;
    localparam int BT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n_a, rst_n_b;
    logic [11:0] medida_a, medida_b;
    logic        pm_a, pm_b;
    logic        ser_a, ser_b, ocu_a, ocu_b, pr_a, pr_b;
    logic [3:0]  db_a, db_b;

    medida_serial_tx #(.BIT_TICKS(BT_A), .CNT_W(9)) u_a (
        .clock(clk), .reset(rst_n_a), .medida(medida_a), .pronto_medida(pm_a),
        .saida_serial(ser_a), .ocupado(ocu_a), .pronto(pr_a), .db_estado(db_a));

    medida_serial_tx #(.BIT_TICKS(BT_B), .CNT_W(3)) u_b (
        .clock(clk), .reset(rst_n_b), .medida(medida_b), .pronto_medida(pm_b),
        .saida_serial(ser_b), .ocupado(ocu_b), .pronto(pr_b), .db_estado(db_b));

    typedef struct {
        logic [31:0] msg;
        bit          gap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stop_mon = 1'b0;
    bit   abort_a = 1'b0;
    bit   abort_b = 1'b0;

    // Reference: each BCD digit becomes '0'+d, a non-BCD nibble becomes '?', then '#'.
    function automatic logic [31:0] ref_msg(input logic [11:0] m);
        logic [31:0] r;
        logic [3:0]  nib;
        r = 32'h0;
        for (int i = 0; i < 3; i++) begin
            nib = m[11 - 4*i -: 4];
            r[31 - 8*i -: 8] = (nib > 4'd9) ? 8'h3F : 8'h30 + {4'h0, nib};
        end
        r[7:0] = 8'h23;
        return r;
    endfunction

    function automatic logic ser(input int w);
        return (w != 0) ? ser_b : ser_a;
    endfunction
    function automatic logic ocu(input int w);
        return (w != 0) ? ocu_b : ocu_a;
    endfunction
    function automatic logic pro(input int w);
        return (w != 0) ? pr_b : pr_a;
    endfunction
    function automatic logic [3:0] dbs(input int w);
        return (w != 0) ? db_b : db_a;
    endfunction
    function automatic string iname(input int w);
        return (w != 0) ? "B" : "A";
    endfunction

    task automatic check(input string name, input int w, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[%s] @cycle %0d: got 0x%0h, expected 0x%0h", name, iname(w), cyc, act, expv);
        end
    endtask

    task automatic set_in(input int w, input logic [11:0] m, input logic p);
        if (w != 0) begin
            medida_b = m;
            pm_b     = p;
        end else begin
            medida_a = m;
            pm_a     = p;
        end
    endtask

    task automatic push_exp(input int w, input logic [11:0] m, input bit gap);
        exp_t e;
        e.msg = ref_msg(m);
        e.gap = gap;
        if (w != 0) q_b.push_back(e);
        else        q_a.push_back(e);
    endtask

    // One-cycle strobe; line must be low and busy high right after the sampling edge.
    task automatic issue(input int w, input logic [11:0] m, output int k);
        @(negedge clk);
        set_in(w, m, 1'b1);
        push_exp(w, m, 1'b0);
        @(negedge clk);
        k = cyc;
        check("start_latency", w, {31'h0, ser(w)}, 32'h0);
        check("busy_at_start", w, {31'h0, ocu(w)}, 32'h1);
        set_in(w, 12'($urandom), 1'b0);
    endtask

    task automatic wait_idle(input int w, input int limit);
        int n;
        n = 0;
        while (ocu(w) !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", w, {31'h0, ocu(w)}, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic monitor(input int w);
        int          bt, c0, last_c0, nmsg, bad;
        bit          aborted;
        exp_t        e;
        logic [7:0]  rx, eb;
        logic [31:0] got;
        logic        lvl;
        logic [3:0]  st;
        bt      = (w != 0) ? BT_B : BT_A;
        last_c0 = -1000000;
        nmsg    = 0;
        while (!stop_mon) begin
            @(negedge clk);
            if (ser(w) !== 1'b0) continue;
            c0 = cyc;
            if (((w != 0) ? q_b.size() : q_a.size()) == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame[%s]: start bit at cycle %0d, expected idle line", iname(w), c0);
                repeat (42 * bt) @(negedge clk);
                continue;
            end
            e = (w != 0) ? q_b.pop_front() : q_a.pop_front();
            if (e.gap) check("msg_gap", w, 32'(c0 - last_c0), 32'(40 * bt + 2));
            last_c0 = c0;
            aborted = 1'b0;
            got     = 32'h0;
            for (int ch = 0; ch < 4; ch++) begin
                eb = e.msg[31 - 8*ch -: 8];
                rx = 8'h00;
                for (int j = 0; j < 10; j++) begin
                    lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[j-1];
                    st  = (j == 0) ? 4'd1 : (j == 9) ? 4'd3 : 4'd2;
                    bad = 0;
                    for (int t = 0; t < bt; t++) begin
                        if (!(ch == 0 && j == 0 && t == 0)) @(negedge clk);
                        if ((w != 0) ? abort_b : abort_a) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (ser(w) !== lvl || dbs(w) !== st || ocu(w) !== 1'b1 || pro(w) !== 1'b0) bad++;
                        if (t == bt / 2 && j >= 1 && j <= 8) rx[j-1] = ser(w);
                    end
                    if (aborted) break;
                    check("bit_cycles_wrong", w, 32'(bad), 32'h0);
                end
                if (aborted) break;
                check("char", w, {24'h0, rx}, {24'h0, eb});
                got[31 - 8*ch -: 8] = rx;
            end
            if (aborted) begin
                if (w != 0) abort_b = 1'b0;
                else        abort_a = 1'b0;
                $display("inst %s msg %0d: aborted by reset at cycle %0d", iname(w), nmsg, cyc);
                nmsg++;
                continue;
            end
            @(negedge clk);
            check("fim_cycle", w, {25'h0, ser(w), ocu(w), pro(w), dbs(w)}, {25'h0, 1'b1, 1'b1, 1'b1, 4'd4});
            @(negedge clk);
            check("after_fim", w, {25'h0, ser(w), ocu(w), pro(w), dbs(w)}, {25'h0, 1'b1, 1'b0, 1'b0, 4'd0});
            $display("inst %s msg %0d start@%0d: rx \"%c%c%c%c\" expected 0x%08h", iname(w), nmsg, c0,
                     got[31:24], got[23:16], got[15:8], got[7:0], e.msg);
            nmsg++;
        end
    endtask

    task automatic stimulus();
        int k, bad;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        set_in(0, 12'h000, 1'b0);
        set_in(1, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++)
            check("reset_state", w, {25'h0, ser(w), ocu(w), pro(w), dbs(w)}, {25'h0, 1'b1, 1'b0, 1'b0, 4'd0});
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        repeat (2) @(negedge clk);

        // Full-rate messages on instance A.
        issue(0, 12'h100, k); wait_idle(0, 20000);
        issue(0, 12'h075, k); wait_idle(0, 20000);
        issue(0, 12'h2A9, k); wait_idle(0, 20000);

        // Random values (including non-BCD nibbles) on instance B.
        for (int i = 0; i < 10; i++) begin
            issue(1, 12'($urandom), k);
            wait_idle(1, 400);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // Strobes while busy (mid-message and in the FIM cycle) are dropped.
        issue(1, 12'h200, k);
        while (cyc < k + 50) @(negedge clk);
        set_in(1, 12'h999, 1'b1);
        @(negedge clk);
        set_in(1, 12'h999, 1'b0);
        while (cyc < k + 40 * BT_B) @(negedge clk);
        set_in(1, 12'h777, 1'b1);
        @(negedge clk);
        set_in(1, 12'h777, 1'b0);
        repeat (40) @(negedge clk);
        check("idle_after_collision", 1, {30'h0, ser(1), ocu(1)}, 32'h2);
        issue(1, 12'h999, k);
        wait_idle(1, 400);

        // Continuous strobe: back-to-back messages with one idle cycle between.
        @(negedge clk);
        set_in(1, 12'h050, 1'b1);
        push_exp(1, 12'h050, 1'b0);
        push_exp(1, 12'h050, 1'b1);
        push_exp(1, 12'h050, 1'b1);
        @(negedge clk);
        check("cont_start_latency", 1, {31'h0, ser(1)}, 32'h0);
        repeat (400) @(negedge clk);
        set_in(1, 12'h050, 1'b0);
        wait_idle(1, 400);

        // Asynchronous reset in the middle of char 1 data bits.
        issue(1, 12'h468, k);
        while (cyc < k + 49) @(negedge clk);
        abort_b = 1'b1;
        #1 rst_n_b = 1'b0;
        #1 check("async_reset", 1, {25'h0, ser(1), ocu(1), pro(1), dbs(1)}, {25'h0, 1'b1, 1'b0, 1'b0, 4'd0});
        repeat (3) @(negedge clk);
        rst_n_b = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (ser(1) !== 1'b1 || ocu(1) !== 1'b0 || dbs(1) !== 4'd0) bad++;
        end
        check("post_reset_idle", 1, 32'(bad), 32'h0);
        issue(1, 12'h321, k);
        wait_idle(1, 400);

        repeat (5) @(negedge clk);
        check("queue_empty", 0, 32'(q_a.size()), 32'h0);
        check("queue_empty", 1, 32'(q_b.size()), 32'h0);
        stop_mon = 1'b1;
    endtask

    initial begin
        fork
            stimulus();
            monitor(0);
            monitor(1);
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
